// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// parity helper used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Parity bit a transmitter must send for this data byte.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits LSB first, parity, 1 stop.
// Emits a one-cycle valid with the byte and parity/framing error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 receiving,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                 w_rx_s;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_odd;
  logic                 r_p_rx;
  logic                 r_last;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_receiving;
  logic                 r_parity_err;
  logic                 r_frame_err;

  uart_rx_sync u_sync (
    .i_clk   (baud_clk),
    .i_reset (reset),
    .i_d     (rx_in),
    .o_q     (w_rx_s)
  );

  // Frame FSM with bit-period counter; all outputs are registered here.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shreg      <= '0;
      r_odd        <= 1'b0;
      r_p_rx       <= 1'b0;
      r_last       <= 1'b0;
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_receiving  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state     <= START;
            r_cnt       <= '0;
            r_odd       <= parity_odd;
            r_receiving <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state     <= IDLE;
              r_receiving <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= PARITY;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PARITY: begin
          if (r_cnt == FULL_M1) begin
            r_p_rx  <= w_rx_s;
            r_cnt   <= '0;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STOP: begin
          // The stop bit is judged one edge after the counter expires.
          if (r_last) begin
            r_last       <= 1'b0;
            r_dout       <= r_shreg;
            r_valid      <= 1'b1;
            r_frame_err  <= ~w_rx_s;
            r_parity_err <= (r_p_rx != calc_parity(r_shreg, r_odd));
            if (w_rx_s) begin
              r_state     <= IDLE;
              r_receiving <= 1'b0;
            end else begin
              r_state <= BREAK;
            end
          end else if (r_cnt == FULL_M1) begin
            r_last <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        BREAK: begin
          if (w_rx_s) begin
            r_state     <= IDLE;
            r_receiving <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_last      <= 1'b0;
          r_receiving <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign receiving  = r_receiving;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: a behavioural transmitter drives
// frames and a scoreboard predicts byte, error flags and valid latency.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS         = 16;
  localparam int LAT        = 3 + OS / 2 + 10 * OS;
  localparam int FRAME_BITS = 2 + DATA_BITS + STOP_BITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       parity_odd = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       receiving;
  logic       parity_err;
  logic       frame_err;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
    int         t0;
  } exp_t;
  exp_t exp_q[$];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .baud_clk   (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .parity_odd (parity_odd),
    .dout       (dout),
    .valid      (valid),
    .receiving  (receiving),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Parity bit a correct transmitter sends: makes the total count of ones even/odd.
  function automatic logic ref_parity_bit(input logic [7:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      n_valid <= n_valid + 1;
      check_eq("valid_width", prev_valid, 1'b0);
      check_eq("valid_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("dout", dout, e.d);
        check_eq("parity_err", parity_err, e.perr);
        check_eq("frame_err", frame_err, e.ferr);
        check_eq("latency", cyc - e.t0, LAT);
      end
    end
    prev_valid <= valid;
  end

  // Behavioural transmitter: drives the first nbits of a frame, OS cycles per bit.
  task automatic drive_frame(input logic [7:0] d, input logic pb, input logic sb,
                             input logic mode, input int nbits, input logic track);
    logic [FRAME_BITS-1:0] bits;
    exp_t e;
    bits = {sb, pb, d, 1'b0};
    parity_odd = mode;
    for (int i = 0; i < nbits; i++) begin
      rx_in = bits[i];
      if (i == 0 && track) begin
        e.d    = d;
        e.perr = (pb != ref_parity_bit(d, mode));
        e.ferr = ~sb;
        e.t0   = cyc + 1;
        exp_q.push_back(e);
      end
      repeat (OS) sync();
      if (i == 0) parity_odd = 1'($urandom);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      sync();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dout"}, dout, 8'h00);
    check_eq({tag, "_valid"}, valid, 1'b0);
    check_eq({tag, "_receiving"}, receiving, 1'b0);
    check_eq({tag, "_parity_err"}, parity_err, 1'b0);
    check_eq({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  initial begin
    int   base;
    logic saw;
    logic [7:0] d;
    logic mode;
    logic pb;

    sync();
    repeat (3) sync();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (4) sync();

    // Clean even-parity frame.
    drive_frame(8'hA5, ref_parity_bit(8'hA5, 1'b0), 1'b1, 1'b0, FRAME_BITS, 1'b1);
    wait_drain("drain_clean");

    // Odd mode with a wrong parity bit; flags must hold afterwards.
    drive_frame(8'h3C, 1'b0, 1'b1, 1'b1, FRAME_BITS, 1'b1);
    wait_drain("drain_badpar");
    repeat (5) sync();
    check_eq("hold_dout", dout, 8'h3C);
    check_eq("hold_parity_err", parity_err, 1'b1);

    // Framing error followed by a held-low line.
    drive_frame(8'h55, ref_parity_bit(8'h55, 1'b0), 1'b0, 1'b0, FRAME_BITS, 1'b1);
    for (int i = 0; i < 100; i++) begin
      sync();
      if (i % 25 == 24) check_eq("break_receiving", receiving, 1'b1);
    end
    rx_in = 1'b1;
    repeat (6) sync();
    check_eq("break_released", receiving, 1'b0);
    check_eq("break_frame_err", frame_err, 1'b1);
    wait_drain("drain_break");

    // Short glitch must be rejected.
    base = n_valid;
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      rx_in = (i < 5) ? 1'b0 : 1'b1;
      sync();
      saw = saw | receiving;
    end
    check_eq("glitch_receiving_pulse", saw, 1'b1);
    check_eq("glitch_idle", receiving, 1'b0);
    check_eq("glitch_no_valid", n_valid - base, 0);
    check_eq("glitch_dout_held", dout, 8'h55);

    // Reset in the middle of data bit 4.
    drive_frame(8'hFF, ref_parity_bit(8'hFF, 1'b0), 1'b1, 1'b0, 5, 1'b0);
    rx_in = 1'b1;
    repeat (OS / 2) sync();
    reset = 1'b1;
    sync();
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (2) sync();
    drive_frame(8'h81, ref_parity_bit(8'h81, 1'b0), 1'b1, 1'b0, FRAME_BITS, 1'b1);
    wait_drain("drain_after_reset");

    // Back-to-back loopback frames.
    base = n_valid;
    drive_frame(8'h00, ref_parity_bit(8'h00, 1'b0), 1'b1, 1'b0, FRAME_BITS, 1'b1);
    drive_frame(8'hFF, ref_parity_bit(8'hFF, 1'b0), 1'b1, 1'b0, FRAME_BITS, 1'b1);
    drive_frame(8'hA5, ref_parity_bit(8'hA5, 1'b0), 1'b1, 1'b0, FRAME_BITS, 1'b1);
    wait_drain("drain_loopback");
    repeat (2) sync();
    check_eq("loopback_count", n_valid - base, 3);

    // Random frames with random mode, parity correctness and idle gaps.
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      mode = 1'($urandom);
      pb   = ($urandom_range(0, 3) == 0) ? ~ref_parity_bit(d, mode) : ref_parity_bit(d, mode);
      drive_frame(d, pb, 1'b1, mode, FRAME_BITS, 1'b1);
      repeat ($urandom_range(0, 12)) sync();
    end
    wait_drain("drain_random");
    repeat (4) sync();
    check_eq("final_idle", receiving, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver paired with uart_tx; it sits directly downstream of the transmitter's out line.
- Frame format matches uart_tx: start (0), 8 data bits LSB first, parity bit, 1 stop (1).
- rx_in is oversampled on baud_clk and each bit is sampled at mid-bit.
- Delivers the received byte with a one-cycle valid strobe, plus parity and framing error flags.

Parameters:
OVERSAMPLE, 16, baud_clk cycles per serial bit; must be even and >= 4.
DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
baud_clk  in  1  sole clock; runs at OVERSAMPLE x bit rate.
reset  in  1  synchronous, active-high reset.
rx_in  in  1  serial line, idle high, asynchronous to baud_clk.
parity_odd  in  1  parity mode: 1 = odd parity, 0 = even parity; latched at frame start.
dout  out  8  last received byte; held until the next valid.
valid  out  1  one-cycle pulse when dout, parity_err and frame_err update.
receiving  out  1  high from start detection until return to IDLE.
parity_err  out  1  parity mismatch on the last frame; held until the next valid.
frame_err  out  1  stop bit sampled 0 on the last frame; held until the next valid.

Behaviour:
- Reset values: dout=0, valid=0, receiving=0, parity_err=0, frame_err=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame: the frame is abandoned, no valid is issued, and the block is in IDLE on the next cycle.
- Synchronization: rx_in passes through a 2-flop synchronizer; rx_s is the synchronized sample. All decisions use rx_s.
- Counters: cnt is a bit-period counter of width clog2(OVERSAMPLE); bit_idx runs 0..7.
- IDLE:
  - If rx_s==0: go to START, cnt=0, latch parity_odd, receiving=1.
- START:
  - cnt increments each cycle.
  - At cnt==OVERSAMPLE/2-1, if rx_s==0: go to DATA, cnt=0, bit_idx=0.
  - At the same point, if rx_s==1: false start; go to IDLE, receiving=0, no valid.
- DATA:
  - At cnt==OVERSAMPLE-1: shift rx_s into shreg MSB (right shift, LSB first), cnt=0, bit_idx++.
  - After bit_idx 7 is sampled, go to PARITY.
- PARITY:
  - At cnt==OVERSAMPLE-1: store rx_s as p_rx, cnt=0, go to STOP.
- STOP:
  - At cnt==OVERSAMPLE-1, on the next edge: dout=shreg, valid=1, and frame_err=~rx_s.
  - On the same edge, parity_err=(p_rx != expected), where expected = ^shreg for even parity and ~^shreg for odd parity.
  - If rx_s==1: go to IDLE with receiving=0.
  - If rx_s==0: go to BREAK.
- BREAK:
  - receiving stays 1.
  - Wait until rx_s==1, then go to IDLE with receiving=0. This prevents a held-low line from retriggering a frame.
- valid: exactly one cycle wide; deasserted in every other cycle.
- Latency: valid rises on the edge 3 + OVERSAMPLE/2 + 10*OVERSAMPLE cycles after the first edge that samples rx_in low. This is 171 for OVERSAMPLE=16.
- Back-to-back frames: a start bit immediately following the stop bit (IDLE for 1 cycle) is accepted with no lost frame.
- Error frames: dout is still updated on parity or frame error; the consumer decides whether to discard it.
- Glitches: a low pulse shorter than OVERSAMPLE/2 cycles is rejected as a false start.

Decomposition:
- Package uart_pkg holds the shared items:
  - state enum {IDLE, START, DATA, PARITY, STOP, BREAK};
  - constants DATA_BITS=8, STOP_BITS=1;
  - function calc_parity(data, odd), also to be used by uart_tx.
- One sub-module, uart_rx_sync: a 2-flop synchronizer with reset value 1.

Test Plan (OVERSAMPLE=16):
- Clean frame, even: drive 0xA5 with parity 0 and stop 1 at 16 cycles/bit, parity_odd=0.
  - Required: valid pulse 171 cycles after the start edge, dout=0xA5, parity_err=0, frame_err=0.
- Bad parity, odd: parity_odd=1, send 0x3C with parity bit 0 (wrong; odd parity requires 1).
  - Required: dout=0x3C, parity_err=1, frame_err=0.
- Framing error and break: send 0x55 with stop=0 and hold the line low for 100 cycles, then release.
  - Required: frame_err=1, receiving stays 1 until release, no second valid.
- False start: 5-cycle low glitch on an idle line.
  - Required: receiving pulses, valid never asserts, block returns to IDLE.
- Reset mid-frame: assert reset during DATA bit 4 of 0xFF.
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Required: a following 0x81 frame is received correctly.
- Loopback: uart_tx at bit rate (baud_clk/16) drives rx_in with 0x00, 0xFF, 0xA5 back-to-back.
  - Required: three valid pulses, dout in order, no error flags.
